// File: rtl/comparator_pkg.sv
// Shared definitions for the comparator sweep engine: FSM encoding,
// vector space size and result bit positions.
package comparator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int VEC_W   = 4;
  localparam int NUM_VEC = 16;
  localparam int ERR_W   = 5;

  // Result word is {GT,EQ,LT}, matching {F1,F2,F3}.
  localparam int RES_GT = 2;
  localparam int RES_EQ = 1;
  localparam int RES_LT = 0;

endpackage

// File: rtl/comparator_2b2b_ref.sv
// Combinational golden model of the 2-bit vs 2-bit magnitude comparator.
// vec_i = {X[1:0], Y[1:0]}; exp_o = {X>Y, X==Y, X<Y}.
module comparator_2b2b_ref
  import comparator_pkg::*;
(
  input  logic [VEC_W-1:0] vec_i,
  output logic [2:0]       exp_o
);

  logic [1:0] x, y;

  always_comb begin
    x = vec_i[3:2];
    y = vec_i[1:0];
    exp_o = '0;
    exp_o[RES_GT] = (x > y);
    exp_o[RES_EQ] = (x == y);
    exp_o[RES_LT] = (x < y);
  end

endmodule

// File: rtl/comparator_sweep_driver.sv
// Sweeps all 16 {A,B,C,D} operand pairs into an external 2b comparator,
// checks F1..F3 against the golden model and reports pass/fail statistics.
module comparator_sweep_driver
  import comparator_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             D,
  input  logic             F1,
  input  logic             F2,
  input  logic             F3,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [VEC_W-1:0] first_err_vec
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] VEC_LAST    = VEC_W'(NUM_VEC - 1);

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               fev_q, fev_d;
  logic [VEC_W-1:0]   fvec_q, fvec_d;

  logic [2:0]         exp_res;
  logic               mismatch;
  logic [ERR_W-1:0]   err_inc;

  comparator_2b2b_ref u_ref (
    .vec_i (vec_q),
    .exp_o (exp_res)
  );

  // Any deviation counts, including multi-hot or all-zero responses.
  assign mismatch = ({F1, F2, F3} != exp_res);
  assign err_inc  = err_q + ERR_W'(mismatch);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fvec_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fvec_q  <= fvec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fvec_d  = fvec_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          vec_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          fev_d   = 1'b0;
          fvec_d  = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          err_d = err_inc;
          if (!fev_q) begin
            fev_d  = 1'b1;
            fvec_d = vec_q;
          end
        end
        // Final verdict must include the vector being sampled right now.
        if (vec_q == VEC_LAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_inc == '0) || !mismatch && (err_q == '0);
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + 1'b1;
          state_d = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign {A, B, C, D}    = vec_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_vec   = fvec_q;

endmodule

// File: tb/tb_comparator_sweep_driver.sv
// Self-checking bench: fault-mode table, randomized comparator responses,
// settle/re-pulse timing and asynchronous reset mid-sweep.
module tb_comparator_sweep_driver;

  logic clk = 1'b0;
  logic rst_n, start, start3;
  always #5 clk = ~clk;

  logic A, B, C, D, F1, F2, F3, busy, done, pass, fev;
  logic [4:0] errc;
  logic [3:0] fvec;
  logic A3, B3, C3, D3, G1, G2, G3, busy3, done3, pass3, fev3;
  logic [4:0] errc3;
  logic [3:0] fvec3;

  int mode;
  logic [2:0] rnd_tbl [16];
  int checks = 0;
  int errors = 0;

  function automatic logic [2:0] golden(int v);
    int x, y;
    x = v / 4;
    y = v % 4;
    return {x > y, x == y, x < y};
  endfunction

  // Stand-in comparator: 0 good, 1 F2 stuck-0, 2 F1/F3 swapped, 3 all-zero, 4 random table
  function automatic logic [2:0] model(int v, int m, logic [2:0] r);
    logic [2:0] g;
    g = golden(v);
    case (m)
      0: return g;
      1: return g & 3'b101;
      2: return {g[0], g[1], g[2]};
      3: return 3'b000;
      default: return r;
    endcase
  endfunction

  assign {F1, F2, F3} = model(int'({A, B, C, D}), mode, rnd_tbl[{A, B, C, D}]);
  assign {G1, G2, G3} = model(int'({A3, B3, C3, D3}), mode, rnd_tbl[{A3, B3, C3, D3}]);

  comparator_sweep_driver #(.SETTLE_CYCLES(1), .CNT_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .A(A), .B(B), .C(C), .D(D), .F1(F1), .F2(F2), .F3(F3),
    .busy(busy), .done(done), .pass(pass), .err_count(errc),
    .first_err_valid(fev), .first_err_vec(fvec)
  );

  comparator_sweep_driver #(.SETTLE_CYCLES(3), .CNT_W(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .A(A3), .B(B3), .C(C3), .D(D3), .F1(G1), .F2(G2), .F3(G3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(errc3),
    .first_err_valid(fev3), .first_err_vec(fvec3)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: walk all 16 operand pairs, count mismatches against golden.
  task automatic ref_sweep(input int m, output int err, output int fv, output int fvv);
    logic [2:0] r;
    err = 0; fv = 0; fvv = 0;
    for (int v = 0; v < 16; v++) begin
      r = model(v, m, rnd_tbl[v]);
      if (r != golden(v)) begin
        if (fv == 0) begin fv = 1; fvv = v; end
        err++;
      end
    end
  endtask

  task automatic run_sweep(output int lat, output int bcnt);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    lat = 0; bcnt = 0;
    while (!done && lat < 400) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input int m);
    int e, f, fv;
    ref_sweep(m, e, f, fv);
    chk({tag, " done"}, int'(done), 1);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " err_count"}, int'(errc), e);
    chk({tag, " first_err_valid"}, int'(fev), f);
    chk({tag, " first_err_vec"}, int'(fvec), fv);
    chk({tag, " pass"}, int'(pass), (e == 0) ? 1 : 0);
    chk({tag, " abcd"}, int'({A, B, C, D}), 15);
  endtask

  typedef struct {
    int mode;
    int err;
    int fev;
    int fvec;
    int pass;
  } vec_t;

  initial begin
    vec_t tbl [4];
    int lat, bcnt, n;

    tbl[0] = '{0, 0, 0, 0, 1};
    tbl[1] = '{1, 4, 1, 0, 0};
    tbl[2] = '{2, 12, 1, 1, 0};
    tbl[3] = '{3, 16, 1, 0, 0};
    for (int v = 0; v < 16; v++) rnd_tbl[v] = golden(v);

    mode = 0; start = 0; start3 = 0; rst_n = 0;
    repeat (2) @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset abcd", int'({A, B, C, D}), 0);
    chk("reset err", int'(errc), 0);
    rst_n = 1;

    // Fault-mode table
    for (int i = 0; i < 4; i++) begin
      mode = tbl[i].mode;
      run_sweep(lat, bcnt);
      chk($sformatf("tbl%0d latency", i), lat, 32);
      chk($sformatf("tbl%0d busy cycles", i), bcnt, 32);
      chk($sformatf("tbl%0d err_count", i), int'(errc), tbl[i].err);
      chk($sformatf("tbl%0d first_err_valid", i), int'(fev), tbl[i].fev);
      chk($sformatf("tbl%0d first_err_vec", i), int'(fvec), tbl[i].fvec);
      chk($sformatf("tbl%0d pass", i), int'(pass), tbl[i].pass);
      chk($sformatf("tbl%0d abcd", i), int'({A, B, C, D}), 15);
    end

    // DONE holds its outputs
    repeat (5) @(negedge clk);
    chk("hold done", int'(done), 1);
    chk("hold abcd", int'({A, B, C, D}), 15);
    chk("hold err", int'(errc), 16);

    // Restart from a faulty DONE: stats clear at the accept edge
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("restart err cleared", int'(errc), 0);
    chk("restart fev cleared", int'(fev), 0);
    chk("restart done cleared", int'(done), 0);
    chk("restart busy", int'(busy), 1);
    n = 0;
    while (!done && n < 400) begin @(negedge clk); n++; end
    chk("restart latency", n, 32);
    check_result("restart", 0);

    // Randomized comparator responses
    for (int it = 0; it < 8; it++) begin
      for (int v = 0; v < 16; v++)
        rnd_tbl[v] = ($urandom_range(1) == 1) ? golden(v) : 3'($urandom_range(7));
      mode = 4;
      run_sweep(lat, bcnt);
      chk($sformatf("rnd%0d latency", it), lat, 32);
      check_result($sformatf("rnd%0d", it), 4);
    end

    // SETTLE_CYCLES=3 with ignored re-pulses
    mode = 0;
    @(negedge clk) start3 = 1'b1;
    @(negedge clk) start3 = 1'b0;
    n = 0;
    while (!done3 && n < 400) begin
      start3 = (n == 5 || n == 20);
      @(negedge clk);
      n++;
    end
    start3 = 1'b0;
    chk("s3 latency", n, 64);
    chk("s3 pass", int'(pass3), 1);
    chk("s3 err", int'(errc3), 0);
    chk("s3 abcd", int'({A3, B3, C3, D3}), 15);

    // Asynchronous reset while vec==7
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (!({A, B, C, D} == 4'd7) && n < 100) begin @(negedge clk); n++; end
    chk("reached vec7", int'({A, B, C, D}), 7);
    #2 rst_n = 1'b0;
    #1;
    chk("async busy", int'(busy), 0);
    chk("async abcd", int'({A, B, C, D}), 0);
    chk("async done", int'(done), 0);
    chk("async err", int'(errc), 0);
    chk("async pass", int'(pass), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post-reset idle", int'(busy), 0);
    run_sweep(lat, bcnt);
    chk("post-reset latency", lat, 32);
    check_result("post-reset", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
